// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from an upstream FIFO and serialises each as a UART frame
// (start, WIDTH data bits LSB first, optional parity, one stop bit) on a registered tx line.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   fifo_empty  FIFO empty flag, only looked at while idle
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read strobe, one registered pulse per byte
//   tx          serial line, idles high
//   busy        high whenever the block is not idle
//   tx_done     one-cycle pulse in the idle cycle that follows a completed stop bit
module uart_tx_fifo_drain #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned     IdxW   = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);
  localparam logic            ParOdd = (PARITY_ODD != 0);
  localparam logic            ParEn  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q, done_d;
  logic              bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CntMax);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        state_d = StWait;
      end
      StWait: begin
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ ParOdd;
        cnt_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
          if (idx_q == IdxMax) begin
            state_d = ParEn ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level and read strobe are decoded from the next state so both are flop outputs.
    rd_en_d = (state_d == StFetch);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign tx_done    = done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (no parity CPB=4, even parity CPB=5,
// odd parity CPB=2), each fed by a 16-deep behavioural FIFO and observed by a line
// receiver that decodes frames from tx alone.
module tb_uart_tx_fifo_drain;

  localparam int NI = 3;
  localparam int FD = 16;

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 5 : 2);
  endfunction
  function automatic int pen_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction
  function automatic int odd_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int nb_of(input int i);
    return 10 + pen_of(i);
  endfunction
  // Expected line level for frame bit k of byte b (no parity): start, data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NI-1:0] fifo_empty, rd_en, tx, busy, tx_done;
  logic [7:0]    fifo_data [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo_drain #(
      .WIDTH       (8),
      .CLKS_PER_BIT(cpb_of(g)),
      .PARITY_EN   (pen_of(g)),
      .PARITY_ODD  (odd_of(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty[g]),
      .fifo_data (fifo_data[g]),
      .fifo_rd_en(rd_en[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .tx_done   (tx_done[g])
    );
  end

  // Behavioural FIFOs: pushes from the stimulus at negedge, pops on rd_en at posedge.
  logic [7:0] mem [NI][FD];
  int wr_cnt [NI];
  int rd_cnt [NI];

  always_comb begin
    for (int i = 0; i < NI; i++) fifo_empty[i] = (wr_cnt[i] == rd_cnt[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd_en[i] && (wr_cnt[i] != rd_cnt[i])) begin
        fifo_data[i] <= mem[i][rd_cnt[i] % FD];
        rd_cnt[i]    <= rd_cnt[i] + 1;
      end
    end
  end

  // Line receiver and event counters.
  int         scyc;
  logic       in_fr    [NI];
  int         k_fr     [NI];
  int         s_fr     [NI];
  int         last_end [NI];
  logic       line     [NI][64];
  logic [7:0] rx_data  [NI][256];
  logic       rx_par   [NI][256];
  int         rx_gap   [NI][256];
  int         rx_n     [NI];
  int         bit_err  [NI];
  int         stop_err [NI];
  int         uf_err   [NI];
  int         done_n   [NI];
  int         rd_n     [NI];

  always @(negedge clk) begin
    int c, nb;
    logic [7:0] d;
    logic v;
    scyc = scyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rd_en[i]) rd_n[i]++;
      if (rd_en[i] && fifo_empty[i]) uf_err[i]++;
      if (tx_done[i]) done_n[i]++;
      if (!rst) begin
        in_fr[i] = 1'b0;
      end else begin
        if (!in_fr[i] && !tx[i]) begin
          in_fr[i] = 1'b1;
          k_fr[i]  = 0;
          s_fr[i]  = scyc;
        end
        if (in_fr[i]) begin
          line[i][k_fr[i]] = tx[i];
          k_fr[i]++;
          c  = cpb_of(i);
          nb = nb_of(i);
          if (k_fr[i] == nb * c) begin
            for (int b = 0; b < nb; b++) begin
              v = line[i][b*c];
              for (int j = 1; j < c; j++) if (line[i][b*c+j] != v) bit_err[i]++;
            end
            for (int b = 0; b < 8; b++) d[b] = line[i][(b+1)*c];
            if (!line[i][(nb-1)*c]) stop_err[i]++;
            rx_data[i][rx_n[i]] = d;
            rx_par[i][rx_n[i]]  = (pen_of(i) != 0) ? line[i][9*c] : 1'b0;
            rx_gap[i][rx_n[i]]  = (last_end[i] < 0) ? -1 : s_fr[i] - last_end[i];
            last_end[i] = s_fr[i] + nb * c;
            rx_n[i]++;
            in_fr[i] = 1'b0;
          end
        end
      end
    end
  end

  int n_cmp, n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, output bit ok);
    ok = (wr_cnt[i] - rd_cnt[i]) < FD;
    if (ok) begin
      mem[i][wr_cnt[i] % FD] = b;
      wr_cnt[i]++;
    end
  endtask

  task automatic wait_rx(input int i, input int target, input int budget, input string name);
    int t = 0;
    while (rx_n[i] < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (rx_n[i] < target) chk({name, "_timeout"}, rx_n[i], target);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } par_vec_t;

  par_vec_t   pv [6];
  logic [7:0] rexp [NI][64];
  int         rn [NI];
  int         rbase [NI];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int bad, base_rx, base_rd, base_dn, idx;
    logic [7:0] b;

    pv[0] = '{8'h07, 1'b1, 1'b0};
    pv[1] = '{8'h03, 1'b0, 1'b1};
    pv[2] = '{8'hFF, 1'b0, 1'b1};
    pv[3] = '{8'h80, 1'b1, 1'b0};
    pv[4] = '{8'h00, 1'b0, 1'b1};
    pv[5] = '{8'hA6, 1'b0, 1'b1};
    for (int i = 0; i < NI; i++) begin
      wr_cnt[i] = 0; rx_n[i] = 0; bit_err[i] = 0; stop_err[i] = 0; uf_err[i] = 0;
      done_n[i] = 0; rd_n[i] = 0; in_fr[i] = 1'b0; last_end[i] = -1;
    end
    n_cmp = 0;
    n_fail = 0;
    scyc = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 7);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_done", int'(tx_done), 0);
    rst = 1'b1;

    // Idle stability with every FIFO empty.
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx != 3'b111 || rd_en != 0 || busy != 0 || tx_done != 0) bad++;
    end
    chk("idle_stable_bad_cycles", bad, 0);

    // Single byte 0x55, cycle-exact.
    base_rx = rx_n[0]; base_rd = rd_n[0]; base_dn = done_n[0];
    @(negedge clk);
    push(0, 8'h55, ok);
    @(negedge clk);
    chk("lat_fetch_rd_en", rd_en[0], 1);
    chk("lat_fetch_tx", tx[0], 1);
    chk("lat_fetch_busy", busy[0], 1);
    @(negedge clk);
    chk("lat_wait_rd_en", rd_en[0], 0);
    chk("lat_wait_tx", tx[0], 1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx[0] != frame_bit(8'h55, k / 4) || !busy[0] || rd_en[0]) bad++;
    end
    chk("single_frame_bad_cycles", bad, 0);
    @(negedge clk);
    chk("single_tx_done", tx_done[0], 1);
    chk("single_busy_low", busy[0], 0);
    chk("single_tx_idle", tx[0], 1);
    @(negedge clk);
    chk("single_tx_done_pulse", tx_done[0], 0);
    chk("single_rd_pulses", rd_n[0] - base_rd, 1);
    chk("single_done_pulses", done_n[0] - base_dn, 1);
    chk("single_rx_count", rx_n[0] - base_rx, 1);
    chk("single_rx_data", rx_data[0][base_rx], 8'h55);

    // Parity table on the even and odd parity instances.
    for (int v = 0; v < 6; v++) begin
      rbase[1] = rx_n[1];
      rbase[2] = rx_n[2];
      @(negedge clk);
      push(1, pv[v].data, ok);
      push(2, pv[v].data, ok);
      wait_rx(1, rbase[1] + 1, 200, "par_even");
      wait_rx(2, rbase[2] + 1, 200, "par_odd");
      chk("par_even_data", rx_data[1][rbase[1]], pv[v].data);
      chk("par_even_bit", rx_par[1][rbase[1]], pv[v].par_even);
      chk("par_odd_data", rx_data[2][rbase[2]], pv[v].data);
      chk("par_odd_bit", rx_par[2][rbase[2]], pv[v].par_odd);
    end

    // Burst of five back-to-back bytes.
    repeat (5) @(negedge clk);
    base_rx = rx_n[0]; base_rd = rd_n[0]; base_dn = done_n[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      push(0, 8'(8'h11 * (k + 1)), ok);
    end
    wait_rx(0, base_rx + 5, 400, "burst");
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) chk("burst_data", rx_data[0][base_rx+k], 8'h11 * (k + 1));
    for (int k = 1; k < 5; k++) chk("burst_gap", rx_gap[0][base_rx+k], 3);
    chk("burst_rd_pulses", rd_n[0] - base_rd, 5);
    chk("burst_done_pulses", done_n[0] - base_dn, 5);

    // Full FIFO drain: fill all 16 under reset, 17th write is dropped by the full FIFO.
    @(negedge clk);
    rst = 1'b0;
    base_rx = rx_n[0]; base_rd = rd_n[0];
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      push(0, 8'(k), ok);
    end
    @(negedge clk);
    push(0, 8'hEE, ok);
    @(negedge clk);
    rst = 1'b1;
    wait_rx(0, base_rx + 16, 16 * 50 + 100, "drain");
    repeat (100) @(negedge clk);
    chk("drain_rx_count", rx_n[0] - base_rx, 16);
    for (int k = 0; k < 16; k++) chk("drain_data", rx_data[0][base_rx+k], k);
    chk("drain_rd_pulses", rd_n[0] - base_rd, 16);
    chk("drain_fifo_empty", fifo_empty[0], 1);

    // Reset in the middle of data bit 3 of 0xA5.
    base_rx = rx_n[0]; base_rd = rd_n[0];
    @(negedge clk);
    push(0, 8'hA5, ok);
    bad = 0;
    while (tx[0] && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    chk("rstmid_start_seen", tx[0], 0);
    repeat (4 * 4 + 1) @(negedge clk);
    chk("rstmid_busy_before", busy[0], 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_tx", tx[0], 1);
    chk("rstmid_busy", busy[0], 0);
    chk("rstmid_rd_en", rd_en[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_no_frame", rx_n[0] - base_rx, 0);
    push(0, 8'hC3, ok);
    wait_rx(0, base_rx + 1, 100, "rstmid_next");
    chk("rstmid_next_data", rx_data[0][base_rx], 8'hC3);
    chk("rstmid_rd_pulses", rd_n[0] - base_rd, 2);

    // Randomised traffic against the frame model.
    for (int i = 0; i < NI; i++) begin
      rbase[i] = rx_n[i];
      rn[i] = 0;
    end
    for (int it = 0; it < 40; it++) begin
      idx = int'($urandom_range(0, NI - 1));
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 30)) @(negedge clk);
      @(negedge clk);
      push(idx, b, ok);
      if (ok) begin
        rexp[idx][rn[idx]] = b;
        rn[idx]++;
      end
    end
    for (int i = 0; i < NI; i++) wait_rx(i, rbase[i] + rn[i], 20000, "rand");
    repeat (5) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < rn[i]; k++) begin
        chk("rand_data", rx_data[i][rbase[i]+k], rexp[i][k]);
        if (pen_of(i) != 0)
          chk("rand_parity", rx_par[i][rbase[i]+k], int'((^rexp[i][k]) ^ odd_of(i)));
      end
    end

    // Whole-run invariants.
    for (int i = 0; i < NI; i++) begin
      chk("underflow_reads", uf_err[i], 0);
      chk("bit_width_errors", bit_err[i], 0);
      chk("stop_bit_errors", stop_err[i], 0);
      chk("done_vs_frames", done_n[i], rx_n[i]);
      chk("rd_pulses_vs_writes", rd_n[i], wr_cnt[i]);
      chk("final_fifo_empty", fifo_empty[i], 1);
      chk("final_tx_idle", tx[i], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Serial transmitter stage directly downstream of `fifo_dualport`: whenever the FIFO reports non-empty, it pops one byte and shifts it out on `tx` as an 8N1 (optional parity) UART frame, LSB first. It owns the FIFO read port (`rd_en`/`data_out`/`empty`) and the physical TX line. This completes the transmit path: host writes into the FIFO, and this block drains it at the baud rate.

## Interface
- `WIDTH`, 8: data bits per frame; must match the FIFO `WIDTH`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Minimum 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 0 selects even parity and 1 selects odd parity.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. The clock is `clk` and the reset is `rst`; there is one clock, and reset is asynchronous and active-low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`. It is valid on the cycle after `fifo_rd_en` was high.
- `fifo_rd_en`  out  1  FIFO `rd_en`. Registered, one-cycle pulse per byte.
- `tx`  out  1  serial line. Idle high.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `fifo_empty`=0, go to FETCH.
- FETCH (1 cycle): `fifo_rd_en`=1. Then go to WAIT.
- WAIT (1 cycle): `fifo_data` is valid. It is captured into the shift register on the exiting edge, together with the parity of the byte (XOR of the data bits, inverted if `PARITY_ODD`). Then go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `tx`=shift[0]. Each bit lasts `CLKS_PER_BIT` cycles and the register shifts right after each bit. After `WIDTH` bits, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY: `tx`=the captured parity bit for `CLKS_PER_BIT` cycles. Then go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then go to IDLE and pulse `tx_done`.
- Counters:
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0 to `CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
  - The bit index is `$clog2(WIDTH)+1` bits wide.
- `tx` is a registered output with no combinational glitches.
- `fifo_empty` is sampled only in IDLE. It is ignored in all other states, because this block is the FIFO's only reader and empty cannot deassert spuriously.
- The block never asserts `fifo_rd_en` while `fifo_empty`=1. An underflow read cannot occur.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0. State is IDLE and the counters are 0.
- Latency: `fifo_empty` falls in IDLE cycle N.
  - Cycle N+1: `fifo_rd_en`=1.
  - Cycle N+2: WAIT.
  - Cycle N+3: first cycle with `tx`=0.
- Frame length: `CLKS_PER_BIT`×(`WIDTH`+2+`PARITY_EN`) cycles from the start-bit edge to the end of the stop bit.
- Back-to-back: `tx_done` is high in the IDLE cycle after STOP. If `fifo_empty`=0 in that same cycle, FETCH follows immediately.
  - The line therefore stays high for exactly 3 extra cycles (IDLE, FETCH, WAIT) beyond the stop bit.
  - `busy` drops for exactly that one IDLE cycle.
- Last byte: if the FIFO became empty through this block's own pop, the next IDLE sees `fifo_empty`=1 and the block stays idle.
- Reset mid-frame: `tx` goes to 1 and the FSM goes to IDLE asynchronously. The in-flight byte is discarded, not re-read.
- A FETCH already issued is never cancelled except by reset.

## Test plan
- Single byte: `CLKS_PER_BIT`=4, `PARITY_EN`=0. Push 0x55 into the FIFO.
  - Required: one `fifo_rd_en` pulse, then `tx` bits 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each exactly 4 cycles.
  - Then `tx_done` pulses once and `busy`=0.
- Parity: `PARITY_EN`=1 and `PARITY_ODD`=0.
  - 0x07 gives a parity bit of 1.
  - 0x03 gives a parity bit of 0.
  - With `PARITY_ODD`=1, both values are inverted.
  - The frame is 11 bits × `CLKS_PER_BIT`.
- Burst: push 0x11, 0x22, 0x33, 0x44, 0x55.
  - Required: exactly 5 `fifo_rd_en` pulses and 5 `tx_done` pulses, with bytes decoded in order.
  - The gap between the stop end and the next start is 3 cycles.
  - `fifo_rd_en` is never high while `fifo_empty`=1.
- Full FIFO drain: fill all 16 entries with 0x00..0x0F.
  - Required: all 16 bytes are serialized in order and the FIFO ends empty.
  - A 17th write attempted while the FIFO is full does not appear on `tx`.
- Reset mid-frame: assert `rst`=0 during the data bit 3 of 0xA5.
  - Required: `tx`=1, `busy`=0 and `fifo_rd_en`=0 immediately, without waiting for a clock.
  - After release with the FIFO holding 0xC3, the next frame is 0xC3, not a resumption of 0xA5.
- Idle stability: with the FIFO empty for 200 cycles after reset, `tx` stays 1 and `fifo_rd_en`, `busy` and `tx_done` stay 0.
